// File: rtl/route_pkg.sv
// Shared constants and types for the two-channel routing FIFO.
// No logic.
// No flow control.
package route_pkg;

    localparam logic ROUTE_CH0   = 1'b0;
    localparam logic ROUTE_CH1   = 1'b1;
    localparam int   ROUTE_WIDTH = 8;
    localparam int   ROUTE_DEPTH = 4;

    typedef logic [ROUTE_WIDTH-1:0] route_word_t;

endpackage

// File: rtl/route_fifo_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a head word that holds its last value when empty.
// Latency: a push is visible at the head after the next rising edge.
// Backpressure: pushes are dropped while full and pops are ignored while empty.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // When empty, the head shows the last word popped (zero after reset).
    assign pop_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/route_fifo.sv
// Steers each input word into one of two independent FIFOs; optional per-channel stats via ROUTE_FIFO_STATS_EN.
// Latency: one cycle from accepted push to valid on the selected output.
// Backpressure: in_ready follows the selected channel's full flag only; a stalled channel never blocks the other.
module route_fifo
    import route_pkg::*;
#(
    parameter  int WIDTH = ROUTE_WIDTH,
    parameter  int DEPTH = ROUTE_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CW-1:0]    count0,
    output logic [CW-1:0]    count1
`ifdef ROUTE_FIFO_STATS_EN
    ,
    output logic [7:0]       stat0,
    output logic [7:0]       stat1
`endif
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;

    assign in_ready   = (in_select == ROUTE_CH1) ? !full1 : !full0;
    assign push0      = in_valid && in_ready && (in_select == ROUTE_CH0);
    assign push1      = in_valid && in_ready && (in_select == ROUTE_CH1);
    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .pop_data  (out0_data),
        .full      (full0),
        .empty     (empty0),
        .count     (count0)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .pop_data  (out1_data),
        .full      (full1),
        .empty     (empty1),
        .count     (count1)
    );

`ifdef ROUTE_FIFO_STATS_EN
    // Accepted-word counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0 <= '0;
            stat1 <= '0;
        end else begin
            if (push0 && (stat0 != 8'hFF)) begin
                stat0 <= stat0 + 8'd1;
            end
            if (push1 && (stat1 != 8'hFF)) begin
                stat1 <= stat1 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_route_fifo.sv
// Directed tests for route_fifo: reset, single push, full, drain order, wrap traffic, mid-run reset, stats.
module tb_route_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_select;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [2:0] count0;
    logic [2:0] count1;
`ifdef ROUTE_FIFO_STATS_EN
    logic [7:0] stat0;
    logic [7:0] stat1;
`endif

    int errors = 0;
    int checks = 0;

    route_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count0     (count0),
        .count1     (count1)
`ifdef ROUTE_FIFO_STATS_EN
        ,
        .stat0      (stat0),
        .stat1      (stat1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it; inputs are changed only at this point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_data    = 8'h00;
        in_select  = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b/%b want 0/0", out0_valid, out1_valid);
        end
        checks++;
        if (count0 !== 3'd0 || count1 !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d/%0d want 0/0", count0, count1);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 00/00", out0_data, out1_data);
        end
    endtask

    task automatic test_single_push();
        do_reset();
        in_data   = 8'hA5;
        in_select = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_out0: got v=%b d=%h want v=1 d=a5", out0_valid, out0_data);
        end
        checks++;
        if (out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_out1_valid: got %b want 0", out1_valid);
        end
        checks++;
        if (count0 !== 3'd1) begin
            errors++;
            $display("FAIL single_count0: got %0d want 1", count0);
        end
    endtask

    task automatic test_full();
        logic [7:0] w;
        do_reset();
        in_select = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            w = 8'(i);
            in_data = w;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (count1 !== 3'd4) begin
            errors++;
            $display("FAIL full_count1: got %0d want 4", count1);
        end
        in_select = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_sel1: got %b want 0", in_ready);
        end
        in_select = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_sel0: got %b want 1", in_ready);
        end
        // Fifth push with a simultaneous pop must still be refused.
        in_select  = 1'b1;
        in_data    = 8'h05;
        in_valid   = 1'b1;
        out1_ready = 1'b1;
        step();
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        checks++;
        if (count1 !== 3'd3 || count0 !== 3'd0) begin
            errors++;
            $display("FAIL full_refused: got c1=%0d c0=%0d want 3/0", count1, count0);
        end
    endtask

    task automatic test_pop_order();
        logic [7:0] w;
        do_reset();
        in_select = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            w = 8'(i);
            in_data = w;
            step();
        end
        in_valid   = 1'b0;
        out1_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            w = 8'(i);
            checks++;
            if (out1_valid !== 1'b1 || out1_data !== w) begin
                errors++;
                $display("FAIL pop_order[%0d]: got v=%b d=%h want v=1 d=%h", i, out1_valid, out1_data, w);
            end
            step();
        end
        out1_ready = 1'b0;
        checks++;
        if (out1_valid !== 1'b0 || count1 !== 3'd0) begin
            errors++;
            $display("FAIL pop_empty: got v=%b c=%0d want 0/0", out1_valid, count1);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp0;
        logic [7:0] exp1;
        int         got0;
        int         got1;
        int         bad_cnt;
        int         bad_dat;
        do_reset();
        exp0 = 8'h00;
        exp1 = 8'h01;
        got0 = 0;
        got1 = 0;
        bad_cnt = 0;
        bad_dat = 0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            if (i < 256) begin
                in_data   = 8'(i);
                in_select = in_data[0];
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out0_valid === 1'b1) begin
                if (out0_data !== exp0) bad_dat++;
                exp0 = exp0 + 8'd2;
                got0++;
            end
            if (out1_valid === 1'b1) begin
                if (out1_data !== exp1) bad_dat++;
                exp1 = exp1 + 8'd2;
                got1++;
            end
            if (count0 > 3'd2 || count1 > 3'd2) bad_cnt++;
            if (i < 256 && in_ready !== 1'b1) bad_cnt++;
            step();
        end
        idle_inputs();
        checks++;
        if (bad_dat !== 0) begin
            errors++;
            $display("FAIL wrap_order: got %0d bad words want 0", bad_dat);
        end
        checks++;
        if (bad_cnt !== 0) begin
            errors++;
            $display("FAIL wrap_count_bound: got %0d violations want 0", bad_cnt);
        end
        checks++;
        if (got0 !== 128 || got1 !== 128) begin
            errors++;
            $display("FAIL wrap_totals: got %0d/%0d want 128/128", got0, got1);
        end
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drained: got %b/%b want 0/0", out0_valid, out1_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_select = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h10 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (count0 !== 3'd3) begin
            errors++;
            $display("FAIL mid_pre_count0: got %0d want 3", count0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count0 !== 3'd0 || out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_clear: got c=%0d v=%b want 0/0", count0, out0_valid);
        end
        #1;
        rst = 1'b0;
        step();
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 8'h3C || count0 !== 3'd1) begin
            errors++;
            $display("FAIL mid_next_word: got v=%b d=%h c=%0d want 1/3c/1", out0_valid, out0_data, count0);
        end
        step();
        out0_ready = 1'b0;
        checks++;
        if (out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_pop: got v=%b want 0", out0_valid);
        end
    endtask

`ifdef ROUTE_FIFO_STATS_EN
    task automatic test_stats();
        do_reset();
        out0_ready = 1'b1;
        in_select  = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i);
            step();
        end
        idle_inputs();
        checks++;
        if (stat0 !== 8'd255 || stat1 !== 8'd0) begin
            errors++;
            $display("FAIL stats_saturate: got %0d/%0d want 255/0", stat0, stat1);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_push();
        test_full();
        test_pop_order();
        test_wrap();
        test_reset_mid();
`ifdef ROUTE_FIFO_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
